// File: rtl/keccak_pkg.sv
// Shared definitions for the slice-streamed Keccak rho/pi engine: FSM states,
// raw FIPS-202 rho offsets and lane-index helpers.
package keccak_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    UNLOAD = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam int NUM_LANES = 25;

  // Rho offsets for a 64-bit lane, indexed by x+5y; reduced per instance.
  localparam int RHO_OFS [NUM_LANES] = '{
     0,  1, 62, 28, 27,
    36, 44,  6, 55, 20,
     3, 10, 43, 25, 39,
    41, 45, 15, 21,  8,
    18,  2, 61, 56, 14
  };

  function automatic int lane_idx(input int x, input int y);
    return x + 5 * y;
  endfunction

  // Lane that pi moves into output lane (x,y).
  function automatic int pi_src(input int x, input int y);
    return lane_idx((x + 3 * y) % 5, x);
  endfunction

endpackage

// File: rtl/keccak_rho_pi_engine_if.sv
// Slice streaming handshake between the round datapath and the rho/pi engine.
interface keccak_rho_pi_engine_if;
  logic        start;
  logic [1:0]  mode;
  logic        hold;
  logic [24:0] in;
  logic        read;
  logic        ready;
  logic        total_ready;
  logic [24:0] out;

  modport master (
    output start, mode, hold, in,
    input  read, ready, total_ready, out
  );

  modport slave (
    input  start, mode, hold, in,
    output read, ready, total_ready, out
  );
endinterface

// File: rtl/keccak_rho_pi_ctrl.sv
// Load/unload sequencer: owns the run FSM, the slice counter and the latched mode.
module keccak_rho_pi_ctrl
  import keccak_pkg::*;
#(
  parameter  int DEPTH = 64,
  localparam int CW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [1:0]    mode,
  input  logic          hold,
  output logic          read,
  output logic          ready,
  output logic          total_ready,
  output logic          we,
  output logic [CW-1:0] idx,
  output logic [1:0]    mode_q
);

  localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    mode_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mode_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    read        = 1'b0;
    ready       = 1'b0;
    total_ready = 1'b0;
    we          = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          cnt_d   = '0;
          mode_d  = mode;
        end
      end
      LOAD: begin
        read  = 1'b1;
        we    = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = UNLOAD;
          cnt_d   = '0;
        end
      end
      UNLOAD: begin
        ready = 1'b1;
        // Terminal slice leaves only once it has actually been accepted.
        if (!hold) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_d = DONE;
            cnt_d   = '0;
          end
        end
      end
      DONE: begin
        total_ready = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign idx = cnt_q;

endmodule

// File: rtl/keccak_rho_pi_engine.sv
// Keccak state buffer that streams slices in and back out with optional rho
// rotation and pi transposition applied on the way out.
module keccak_rho_pi_engine
  import keccak_pkg::*;
#(
  parameter  int DEPTH = 64,
  localparam int CW    = $clog2(DEPTH)
) (
  input logic                   clk,
  input logic                   rst,
  keccak_rho_pi_engine_if.slave bus
);

  logic          read, ready, total_ready, we;
  logic [CW-1:0] idx;
  logic [1:0]    mode_q;

  keccak_rho_pi_ctrl #(.DEPTH(DEPTH)) u_ctrl (
    .clk         (clk),
    .rst         (rst),
    .start       (bus.start),
    .mode        (bus.mode),
    .hold        (bus.hold),
    .read        (read),
    .ready       (ready),
    .total_ready (total_ready),
    .we          (we),
    .idx         (idx),
    .mode_q      (mode_q)
  );

  // Slice z of lane L lives at lane_q[L][z].
  logic [NUM_LANES-1:0][DEPTH-1:0] lane_q, lane_d;

  always_comb begin
    lane_d = lane_q;
    if (we) begin
      for (int l = 0; l < NUM_LANES; l++) lane_d[l][idx] = bus.in[l];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lane_q <= '0;
    else      lane_q <= lane_d;
  end

  logic [NUM_LANES-1:0] out_raw;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    localparam int X    = l % 5;
    localparam int Y    = l / 5;
    localparam int PSRC = pi_src(X, Y);
    // Offsets are pre-reduced; DEPTH is a power of two so idx-rot wraps for free.
    localparam int R_ID = RHO_OFS[l] % DEPTH;
    localparam int R_PI = RHO_OFS[PSRC] % DEPTH;

    logic [4:0]    src;
    logic [CW-1:0] rot;
    logic [CW-1:0] sz;

    assign src        = mode_q[1] ? 5'(PSRC) : 5'(l);
    assign rot        = !mode_q[0] ? '0 : (mode_q[1] ? CW'(R_PI) : CW'(R_ID));
    assign sz         = idx - rot;
    assign out_raw[l] = lane_q[src][sz];
  end

  assign bus.read        = read;
  assign bus.ready       = ready;
  assign bus.total_ready = total_ready;
  assign bus.out         = ready ? out_raw : '0;

endmodule

// File: tb/tb_keccak_rho_pi_engine.sv
// Randomised bench for the rho/pi engine at DEPTH=64 and DEPTH=8 against a
// lane/slice array model of the transform.
module tb_keccak_rho_pi_engine;

  localparam int RHO [25] = '{0, 1, 62, 28, 27, 36, 44, 6, 55, 20, 3, 10, 43,
                              25, 39, 41, 45, 15, 21, 8, 18, 2, 61, 56, 14};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  keccak_rho_pi_engine_if if0 ();
  keccak_rho_pi_engine_if if1 ();

  keccak_rho_pi_engine #(.DEPTH(64)) u_d64 (.clk(clk), .rst(rst), .bus(if0));
  keccak_rho_pi_engine #(.DEPTH(8))  u_d8  (.clk(clk), .rst(rst), .bus(if1));

  logic             start_v [2];
  logic [1:0]       mode_v  [2];
  logic             hold_v  [2];
  logic [24:0]      in_v    [2];
  logic [1:0]       rd, rdy, tr;
  logic [1:0][24:0] ov;

  assign if0.start = start_v[0];
  assign if0.mode  = mode_v[0];
  assign if0.hold  = hold_v[0];
  assign if0.in    = in_v[0];
  assign if1.start = start_v[1];
  assign if1.mode  = mode_v[1];
  assign if1.hold  = hold_v[1];
  assign if1.in    = in_v[1];
  assign rd  = {if1.read, if0.read};
  assign rdy = {if1.ready, if0.ready};
  assign tr  = {if1.total_ready, if0.total_ready};
  assign ov  = {if1.out, if0.out};

  logic [24:0] mem [64];
  logic [24:0] cap [64];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Output lane (x,y) at slice z draws from lane (sx,sy) at slice z - R[sx,sy].
  function automatic logic [24:0] ref_slice(input int z, input logic [1:0] m, input int dd);
    logic [24:0] r;
    r = '0;
    for (int y = 0; y < 5; y++) begin
      for (int x = 0; x < 5; x++) begin
        int sx, sy, sl, sh, s;
        sx = x;
        sy = y;
        if (m[1]) begin
          sx = (x + 3 * y) % 5;
          sy = x;
        end
        sl = sx + 5 * sy;
        sh = m[0] ? RHO[sl] % dd : 0;
        s  = (z - sh + dd) % dd;
        r[x + 5 * y] = mem[s][sl];
      end
    end
    return r;
  endfunction

  task automatic run(input int d, input logic [1:0] m, input int hold_at, input int hold_len,
                     input bit glitch, input int abort_at);
    int dd, z, hc, cyc;
    dd = (d == 1) ? 8 : 64;
    @(negedge clk);
    chk("idle_ready", 32'(rdy[d]), 0);
    chk("idle_read", 32'(rd[d]), 0);
    start_v[d] = 1'b1;
    mode_v[d]  = m;
    cyc = 1;
    for (int i = 0; i < dd; i++) begin
      @(negedge clk);
      cyc++;
      start_v[d] = glitch && (i == 3);
      mode_v[d]  = 2'($urandom);
      chk("load_read", 32'(rd[d]), 1);
      chk("load_ready", 32'(rdy[d]), 0);
      in_v[d] = mem[i];
    end
    z  = 0;
    hc = 0;
    while (z < dd) begin
      @(negedge clk);
      cyc++;
      start_v[d] = 1'b0;
      in_v[d]    = 25'($urandom);
      chk("unload_ready", 32'(rdy[d]), 1);
      chk("unload_read", 32'(rd[d]), 0);
      chk($sformatf("out_d%0d_m%0d_z%0d", dd, m, z), 32'(ov[d]), 32'(ref_slice(z, m, dd)));
      cap[z] = ov[d];
      if (z == abort_at) begin
        rst = 1'b0;
        #1;
        chk("abort_ready", 32'(rdy[d]), 0);
        chk("abort_out", 32'(ov[d]), 0);
        chk("abort_read", 32'(rd[d]), 0);
        chk("abort_total", 32'(tr[d]), 0);
        hold_v[d] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        return;
      end
      if (z == hold_at && hc < hold_len) begin
        hold_v[d] = 1'b1;
        hc++;
      end else begin
        hold_v[d] = 1'b0;
        z++;
      end
    end
    @(negedge clk);
    cyc++;
    chk("done_total", 32'(tr[d]), 1);
    chk("done_ready", 32'(rdy[d]), 0);
    chk("latency", 32'(cyc), 32'(2 * dd + 2 + hc));
    start_v[d] = glitch;
    @(negedge clk);
    chk("total_pulse", 32'(tr[d]), 0);
    chk("done_start_ignored", 32'(rd[d]), 0);
    start_v[d] = 1'b0;
  endtask

  task automatic fill_rand();
    for (int i = 0; i < 64; i++) mem[i] = 25'($urandom);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      start_v[d] = 1'b0;
      mode_v[d]  = 2'b00;
      hold_v[d]  = 1'b0;
      in_v[d]    = '0;
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_read", 32'(rd), 0);
    chk("rst_ready", 32'(rdy), 0);
    chk("rst_total", 32'(tr), 0);
    chk("rst_out0", 32'(ov[0]), 0);
    chk("rst_out1", 32'(ov[1]), 0);
    rst = 1'b1;

    // identity pass with a slice-index pattern
    for (int i = 0; i < 64; i++) begin
      logic [4:0] t;
      t = 5'(i);
      mem[i] = {15'b0, t, t};
    end
    run(0, 2'b00, -1, 0, 1'b0, -1);

    // single-bit rho checks on lanes 1 and 2
    for (int i = 0; i < 64; i++) mem[i] = '0;
    mem[0] = 25'h2;
    run(0, 2'b01, -1, 0, 1'b0, -1);
    chk("rho_lane1_z1", 32'(cap[1]), 32'h2);
    chk("rho_lane1_z0", 32'(cap[0]), 32'h0);
    mem[0] = 25'h4;
    run(0, 2'b01, -1, 0, 1'b0, -1);
    chk("rho_lane2_z62", 32'(cap[62]), 32'h4);
    chk("rho_lane2_z63", 32'(cap[63]), 32'h0);

    // pi only: lane (1,0) lands in lane (0,2)
    for (int i = 0; i < 64; i++) mem[i] = 25'h2;
    run(0, 2'b10, -1, 0, 1'b0, -1);
    for (int i = 0; i < 64; i += 9) chk($sformatf("pi_z%0d", i), 32'(cap[i]), 32'h400);

    // rho+pi at DEPTH=8, plus random modes
    for (int k = 0; k < 3; k++) begin
      fill_rand();
      run(1, 2'b11, -1, 0, 1'b0, -1);
    end
    for (int k = 0; k < 4; k++) begin
      fill_rand();
      run(1, 2'($urandom), int'($urandom_range(0, 7)), int'($urandom_range(0, 3)), 1'b1, -1);
    end

    // backpressure at z=10 with start glitches in LOAD and DONE
    fill_rand();
    run(0, 2'b11, 10, 5, 1'b1, -1);

    // reset in UNLOAD, then a fresh run
    fill_rand();
    run(0, 2'b11, -1, 0, 1'b0, 20);
    fill_rand();
    run(0, 2'b01, -1, 0, 1'b0, -1);
    fill_rand();
    run(0, 2'($urandom), 33, 2, 1'b0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
